// File: rtl/match_controller.sv
// Round/match sequencer: frame-tick timing, countdown, KO detection, best-of-N tally.
// Optional round timer enabled by defining MATCH_TIMER_EN.
module match_controller #(
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned COUNT_SECS     = 3,
  parameter int unsigned KO_HOLD_FRAMES = 120,
  parameter int unsigned WINS_TO_MATCH  = 2,
  parameter int unsigned ROUND_SECS     = 60
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       vs,
  input  logic       start,
  input  logic [9:0] player_hp1,
  input  logic [9:0] player_hp2,
  output logic [2:0] state,
  output logic       players_en,
  output logic       round_rst,
  output logic [1:0] countdown,
  output logic [3:0] round_num,
  output logic [1:0] wins1,
  output logic [1:0] wins2,
  output logic [1:0] round_winner,
  output logic [1:0] match_winner,
  output logic [6:0] secs_left
);

`ifdef MATCH_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  localparam int unsigned MAX_FRAMES = (FRAMES_PER_SEC > KO_HOLD_FRAMES) ? FRAMES_PER_SEC : KO_HOLD_FRAMES;
  localparam int unsigned FW         = $clog2(MAX_FRAMES + 1);
  localparam logic [FW-1:0] SEC_LAST = FW'(FRAMES_PER_SEC - 1);
  localparam logic [FW-1:0] KO_LAST  = FW'(KO_HOLD_FRAMES - 1);
  localparam logic [1:0] WIN_MAX     = 2'(WINS_TO_MATCH);
  localparam logic [1:0] COUNT_INIT  = 2'(COUNT_SECS);
  localparam logic [6:0] ROUND_INIT  = TIMER_EN ? 7'(ROUND_SECS) : 7'd0;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COUNTDOWN  = 3'd1,
    FIGHT      = 3'd2,
    KO         = 3'd3,
    MATCH_OVER = 3'd4
  } fsm_t;

  fsm_t          fsm;
  logic          vs_q;
  logic          start_q;
  logic [FW-1:0] frame_cnt;

  logic       frame_tick;
  logic       start_edge;
  logic       sec_end;
  logic       timeout;
  logic [1:0] result;

  assign frame_tick = vs_q & ~vs;
  assign start_edge = start & ~start_q;
  assign state      = fsm;

  // Round outcome for the current frame; a KO always outranks the timeout.
  always_comb begin
    sec_end = (frame_cnt == SEC_LAST);
    timeout = TIMER_EN && sec_end && (secs_left == 7'd1);
    result  = 2'd0;
    if (player_hp1 == '0 && player_hp2 == '0)
      result = 2'd3;
    else if (player_hp2 == '0)
      result = 2'd1;
    else if (player_hp1 == '0)
      result = 2'd2;
    else if (timeout) begin
      if (player_hp1 > player_hp2)
        result = 2'd1;
      else if (player_hp2 > player_hp1)
        result = 2'd2;
      else
        result = 2'd3;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fsm          <= IDLE;
      vs_q         <= 1'b0;
      start_q      <= 1'b0;
      frame_cnt    <= '0;
      players_en   <= 1'b0;
      round_rst    <= 1'b0;
      countdown    <= '0;
      round_num    <= '0;
      wins1        <= '0;
      wins2        <= '0;
      round_winner <= '0;
      match_winner <= '0;
      secs_left    <= '0;
    end else begin
      vs_q      <= vs;
      start_q   <= start;
      round_rst <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start_edge) begin
            round_num    <= 4'd1;
            wins1        <= '0;
            wins2        <= '0;
            round_winner <= '0;
            round_rst    <= 1'b1;
            countdown    <= COUNT_INIT;
            frame_cnt    <= '0;
            fsm          <= COUNTDOWN;
          end
        end
        COUNTDOWN: begin
          if (frame_tick) begin
            if (sec_end) begin
              frame_cnt <= '0;
              if (countdown == 2'd1) begin
                countdown  <= '0;
                players_en <= 1'b1;
                secs_left  <= ROUND_INIT;
                fsm        <= FIGHT;
              end else begin
                countdown <= countdown - 2'd1;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        FIGHT: begin
          if (frame_tick) begin
            if (result != 2'd0) begin
              round_winner <= result;
              if (result == 2'd1 && wins1 != WIN_MAX)
                wins1 <= wins1 + 2'd1;
              if (result == 2'd2 && wins2 != WIN_MAX)
                wins2 <= wins2 + 2'd1;
              players_en <= 1'b0;
              secs_left  <= '0;
              frame_cnt  <= '0;
              fsm        <= KO;
            end else if (sec_end) begin
              frame_cnt <= '0;
              if (TIMER_EN)
                secs_left <= secs_left - 7'd1;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        KO: begin
          if (frame_tick) begin
            if (frame_cnt == KO_LAST) begin
              frame_cnt <= '0;
              if (wins1 == WIN_MAX) begin
                match_winner <= 2'd1;
                fsm          <= MATCH_OVER;
              end else if (wins2 == WIN_MAX) begin
                match_winner <= 2'd2;
                fsm          <= MATCH_OVER;
              end else begin
                if (round_num != 4'd15)
                  round_num <= round_num + 4'd1;
                round_rst <= 1'b1;
                countdown <= COUNT_INIT;
                fsm       <= COUNTDOWN;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        MATCH_OVER: begin
          if (start_edge) begin
            match_winner <= '0;
            frame_cnt    <= '0;
            fsm          <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
